// File: rtl/yamin_stb_nc_drain.sv
// rtl/yamin_stb_nc_drain.sv - drains the oldest non-cacheable STB slot to the BIU in strict order
// Optional watchdog: define YAMIN_STB_DRAIN_TIMEOUT_EN to enable the REQ-phase timeout counter.
module yamin_stb_nc_drain (
  input  logic        clk,
  input  logic        csysreset_n,
  input  logic [3:0]  stb_slots_valid_i,
  input  logic [3:0]  stb_slots_ch_i,
  input  logic [1:0]  stb_oldest_slot_i,
  input  logic [31:0] stb_slot_addr_i,
  input  logic [31:0] stb_slot_data_i,
  input  logic [3:0]  stb_slot_wstrb_i,
  input  logic        drain_entire_i,
  output logic [1:0]  drain_sel_o,
  output logic        stb_biu_write_req_o,
  output logic [31:0] stb_biu_write_addr_o,
  output logic [31:0] stb_biu_write_data_o,
  output logic [3:0]  stb_biu_write_wstrb_o,
  output logic [3:0]  stb_biu_write_slot_o,
  input  logic        biu_stb_write_ack_i,
  output logic [3:0]  retire_o,
  output logic        busy_o,
  output logic        nc_drained_o,
  output logic        timeout_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_RETIRE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        cand;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [3:0]  wstrb_q;
  logic [3:0]  slot_q;

  // Only the oldest slot may drain, and only if it is valid and non-cacheable
  assign cand        = stb_slots_valid_i[stb_oldest_slot_i] & ~stb_slots_ch_i[stb_oldest_slot_i];
  assign drain_sel_o = stb_oldest_slot_i;

  // State register
  always_ff @(posedge clk or negedge csysreset_n) begin
    if (!csysreset_n) state <= S_IDLE;
    else              state <= state_nxt;
  end

  // Next-state logic: RETIRE always returns to IDLE so a store takes at least three cycles
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (cand) state_nxt = S_REQ;
      S_REQ:    if (biu_stb_write_ack_i) state_nxt = S_RETIRE;
      S_RETIRE: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Capture the candidate's fields on leaving IDLE; they stay frozen through REQ and RETIRE
  always_ff @(posedge clk or negedge csysreset_n) begin
    if (!csysreset_n) begin
      addr_q  <= 32'h0;
      data_q  <= 32'h0;
      wstrb_q <= 4'h0;
      slot_q  <= 4'h0;
    end else if (state == S_IDLE && cand) begin
      addr_q  <= stb_slot_addr_i;
      data_q  <= stb_slot_data_i;
      wstrb_q <= stb_slot_wstrb_i;
      slot_q  <= 4'b0001 << stb_oldest_slot_i;
    end
  end

  // Outputs decoded from state so an async reset drops the request immediately
  always_comb begin
    stb_biu_write_req_o = (state == S_REQ);
    retire_o            = (state == S_RETIRE) ? slot_q : 4'h0;
    busy_o              = (state != S_IDLE);
    nc_drained_o        = (state == S_IDLE) && ((stb_slots_valid_i & ~stb_slots_ch_i) == 4'h0);
  end

  assign stb_biu_write_addr_o  = addr_q;
  assign stb_biu_write_data_o  = data_q;
  assign stb_biu_write_wstrb_o = wstrb_q;
  assign stb_biu_write_slot_o  = slot_q;

`ifdef YAMIN_STB_DRAIN_TIMEOUT_EN
  logic [7:0] to_cnt;
  logic       to_q;
  logic       to_set;

  // Timeout fires in the REQ cycle where the saturated count is seen, then holds via to_q
  assign to_set = (state == S_REQ) && (to_cnt == 8'hFF) && drain_entire_i;

  // Watchdog counter cleared on REQ entry, saturating; sticky flag cleared in RETIRE
  always_ff @(posedge clk or negedge csysreset_n) begin
    if (!csysreset_n) begin
      to_cnt <= 8'h0;
      to_q   <= 1'b0;
    end else begin
      if (state == S_IDLE && cand)                to_cnt <= 8'h0;
      else if (state == S_REQ && to_cnt != 8'hFF) to_cnt <= to_cnt + 8'h1;
      if (state == S_RETIRE) to_q <= 1'b0;
      else if (to_set)       to_q <= 1'b1;
    end
  end

  assign timeout_o = to_q | to_set;
`else
  logic unused_drain_entire;
  assign unused_drain_entire = drain_entire_i;
  assign timeout_o           = 1'b0;
`endif

endmodule

// File: tb/tb_yamin_stb_nc_drain.sv
// tb/tb_yamin_stb_nc_drain.sv - directed scoreboard bench for yamin_stb_nc_drain
module tb_yamin_stb_nc_drain;

`ifdef YAMIN_STB_DRAIN_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  wstrb;
    logic [3:0]  slot;
  } wr_t;

  logic        clk = 1'b0;
  logic        csysreset_n;
  logic [3:0]  stb_slots_valid_i;
  logic [3:0]  stb_slots_ch_i;
  logic [1:0]  stb_oldest_slot_i;
  logic [31:0] stb_slot_addr_i;
  logic [31:0] stb_slot_data_i;
  logic [3:0]  stb_slot_wstrb_i;
  logic        drain_entire_i;
  logic [1:0]  drain_sel_o;
  logic        stb_biu_write_req_o;
  logic [31:0] stb_biu_write_addr_o;
  logic [31:0] stb_biu_write_data_o;
  logic [3:0]  stb_biu_write_wstrb_o;
  logic [3:0]  stb_biu_write_slot_o;
  logic        biu_stb_write_ack_i;
  logic [3:0]  retire_o;
  logic        busy_o;
  logic        nc_drained_o;
  logic        timeout_o;

  int   vectors = 0;
  int   errors  = 0;
  wr_t  exp_q[$];
  logic [3:0] ret_q[$];
  wr_t  cur;
  logic [3:0] cur_ret;

  yamin_stb_nc_drain dut (
    .clk                   (clk),
    .csysreset_n           (csysreset_n),
    .stb_slots_valid_i     (stb_slots_valid_i),
    .stb_slots_ch_i        (stb_slots_ch_i),
    .stb_oldest_slot_i     (stb_oldest_slot_i),
    .stb_slot_addr_i       (stb_slot_addr_i),
    .stb_slot_data_i       (stb_slot_data_i),
    .stb_slot_wstrb_i      (stb_slot_wstrb_i),
    .drain_entire_i        (drain_entire_i),
    .drain_sel_o           (drain_sel_o),
    .stb_biu_write_req_o   (stb_biu_write_req_o),
    .stb_biu_write_addr_o  (stb_biu_write_addr_o),
    .stb_biu_write_data_o  (stb_biu_write_data_o),
    .stb_biu_write_wstrb_o (stb_biu_write_wstrb_o),
    .stb_biu_write_slot_o  (stb_biu_write_slot_o),
    .biu_stb_write_ack_i   (biu_stb_write_ack_i),
    .retire_o              (retire_o),
    .busy_o                (busy_o),
    .nc_drained_o          (nc_drained_o),
    .timeout_o             (timeout_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present one candidate slot and queue the write and retire it must produce
  task automatic present(input logic [1:0] idx, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] w);
    wr_t e;
    stb_oldest_slot_i = idx;
    stb_slots_valid_i = 4'b0001 << idx;
    stb_slots_ch_i    = 4'h0;
    stb_slot_addr_i   = a;
    stb_slot_data_i   = d;
    stb_slot_wstrb_i  = w;
    e.addr  = a;
    e.data  = d;
    e.wstrb = w;
    e.slot  = 4'b0001 << idx;
    exp_q.push_back(e);
    ret_q.push_back(e.slot);
  endtask

  task automatic pop_write();
    chk("sb_write_pending", 64'(exp_q.size() != 0), 64'd1);
    if (exp_q.size() != 0) cur = exp_q.pop_front();
  endtask

  task automatic pop_retire();
    chk("sb_retire_pending", 64'(ret_q.size() != 0), 64'd1);
    if (ret_q.size() != 0) cur_ret = ret_q.pop_front();
  endtask

  task automatic chk_req(input string tag);
    chk({tag, "_req"},   64'(stb_biu_write_req_o),   64'd1);
    chk({tag, "_addr"},  64'(stb_biu_write_addr_o),  64'(cur.addr));
    chk({tag, "_data"},  64'(stb_biu_write_data_o),  64'(cur.data));
    chk({tag, "_wstrb"}, 64'(stb_biu_write_wstrb_o), 64'(cur.wstrb));
    chk({tag, "_slot"},  64'(stb_biu_write_slot_o),  64'(cur.slot));
    chk({tag, "_retire0"}, 64'(retire_o), 64'd0);
    chk({tag, "_busy"},  64'(busy_o), 64'd1);
  endtask

  initial begin
    cur     = '0;
    cur_ret = 4'h0;
    csysreset_n         = 1'b0;
    stb_slots_valid_i   = 4'h0;
    stb_slots_ch_i      = 4'h0;
    stb_oldest_slot_i   = 2'd0;
    stb_slot_addr_i     = 32'h0;
    stb_slot_data_i     = 32'h0;
    stb_slot_wstrb_i    = 4'h0;
    drain_entire_i      = 1'b0;
    biu_stb_write_ack_i = 1'b0;

    // Reset state
    cyc();
    cyc();
    chk("rst_req",     64'(stb_biu_write_req_o),  64'd0);
    chk("rst_retire",  64'(retire_o),             64'd0);
    chk("rst_busy",    64'(busy_o),               64'd0);
    chk("rst_timeout", 64'(timeout_o),            64'd0);
    chk("rst_addr",    64'(stb_biu_write_addr_o), 64'd0);
    chk("rst_slot",    64'(stb_biu_write_slot_o), 64'd0);
    chk("rst_ncdrained_empty", 64'(nc_drained_o), 64'd1);
    stb_slots_valid_i = 4'b0100;
    #1;
    chk("rst_ncdrained_nc", 64'(nc_drained_o), 64'd0);
    stb_slots_valid_i = 4'h0;
    csysreset_n = 1'b1;

    // Slot 2 store, ack after 5 low cycles; slot valid and fields disturbed mid-REQ
    cyc();
    present(2'd2, 32'h4000_0010, 32'hDEAD_BEEF, 4'hF);
    #1;
    chk("idle_drain_sel", 64'(drain_sel_o), 64'd2);
    chk("idle_req",       64'(stb_biu_write_req_o), 64'd0);
    chk("idle_ncdrained", 64'(nc_drained_o), 64'd0);
    chk("idle_busy",      64'(busy_o), 64'd0);
    for (int k = 1; k <= 6; k++) begin
      cyc();
      if (k == 1) pop_write();
      if (k == 3) begin
        stb_slots_valid_i = 4'h0;
        stb_slot_addr_i   = 32'h1234_5678;
        stb_slot_data_i   = 32'h0;
        stb_slot_wstrb_i  = 4'h1;
      end
      biu_stb_write_ack_i = (k == 6);
      #1;
      chk_req("s2_req");
      chk("s2_ncdrained_busy", 64'(nc_drained_o), 64'd0);
    end
    // RETIRE: a fresh candidate here must not be sampled
    cyc();
    pop_retire();
    present(2'd1, 32'h8000_0004, 32'hCAFE_0001, 4'h3);
    #1;
    chk("s2_ret_req",    64'(stb_biu_write_req_o), 64'd0);
    chk("s2_ret_retire", 64'(retire_o), 64'(cur_ret));
    chk("s2_ret_busy",   64'(busy_o), 64'd1);
    cyc();
    biu_stb_write_ack_i = 1'b1;
    #1;
    chk("s2_idle_req",    64'(stb_biu_write_req_o), 64'd0);
    chk("s2_idle_retire", 64'(retire_o), 64'd0);
    chk("s2_idle_busy",   64'(busy_o), 64'd0);

    // Slot 1 store with ack present on the first REQ cycle
    cyc();
    pop_write();
    #1;
    chk_req("s1_req");
    cyc();
    pop_retire();
    stb_slots_valid_i   = 4'h0;
    biu_stb_write_ack_i = 1'b0;
    #1;
    chk("s1_ret_req",    64'(stb_biu_write_req_o), 64'd0);
    chk("s1_ret_retire", 64'(retire_o), 64'(cur_ret));
    cyc();
    chk("s1_idle_retire", 64'(retire_o), 64'd0);
    chk("s1_idle_busy",   64'(busy_o), 64'd0);

    // Oldest slot cacheable blocks a younger non-cacheable slot; stray ack ignored
    stb_oldest_slot_i   = 2'd0;
    stb_slots_valid_i   = 4'b0011;
    stb_slots_ch_i      = 4'b0001;
    biu_stb_write_ack_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("ch_req",       64'(stb_biu_write_req_o), 64'd0);
      chk("ch_busy",      64'(busy_o), 64'd0);
      chk("ch_retire",    64'(retire_o), 64'd0);
      chk("ch_ncdrained", 64'(nc_drained_o), 64'd0);
    end
    stb_slots_valid_i = 4'b0001;
    #1;
    chk("ch_only_ncdrained", 64'(nc_drained_o), 64'd1);
    biu_stb_write_ack_i = 1'b0;

    // Reset asserted mid-REQ drops the request at once and never retires
    present(2'd3, 32'hA5A5_0000, 32'h0F0F_F0F0, 4'h6);
    cyc();
    pop_write();
    #1;
    chk_req("s3_req");
    pop_retire();
    csysreset_n = 1'b0;
    biu_stb_write_ack_i = 1'b1;
    #1;
    chk("s3_rst_req",  64'(stb_biu_write_req_o), 64'd0);
    chk("s3_rst_busy", 64'(busy_o), 64'd0);
    chk("s3_rst_slot", 64'(stb_biu_write_slot_o), 64'd0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      if (k == 1) begin
        stb_slots_valid_i = 4'h0;
        csysreset_n = 1'b1;
      end
      #1;
      chk("s3_no_retire", 64'(retire_o), 64'd0);
      chk("s3_no_req",    64'(stb_biu_write_req_o), 64'd0);
    end
    biu_stb_write_ack_i = 1'b0;

    // Watchdog: no ack for 260 REQ cycles with drain_entire high
    drain_entire_i = 1'b1;
    present(2'd0, 32'h4000_0100, 32'h1111_2222, 4'hC);
    for (int k = 1; k <= 261; k++) begin
      cyc();
      if (k == 1) pop_write();
      biu_stb_write_ack_i = (k == 261);
      #1;
      chk("wd_req",     64'(stb_biu_write_req_o), 64'd1);
      chk("wd_timeout", 64'(timeout_o), 64'(TO_EN && k >= 256));
    end
    cyc();
    pop_retire();
    stb_slots_valid_i   = 4'h0;
    biu_stb_write_ack_i = 1'b0;
    #1;
    chk("wd_ret_retire",  64'(retire_o), 64'(cur_ret));
    chk("wd_ret_timeout", 64'(timeout_o), 64'(TO_EN));
    cyc();
    chk("wd_idle_timeout", 64'(timeout_o), 64'd0);
    chk("wd_idle_busy",    64'(busy_o), 64'd0);
    drain_entire_i = 1'b0;

    chk("sb_write_empty",  64'(exp_q.size()), 64'd0);
    chk("sb_retire_empty", 64'(ret_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
